base_ram_arbiter: RTL and testbench

Single-port SRAM arbiter that shares one external base RAM between the instruction-fetch requester (IF stage) and the data requester (MEM stage loads and stores). It grants one access at a time and drives the SRAM control pins for a fixed `RAM_LAT` cycles. It returns read data to the owner with a one-cycle response pulse. Data accesses have priority, and a starvation counter guarantees forward progress for fetch.

---
 rtl/base_ram_arbiter.sv | 166 ++++++++++++++++
 tb/tb_base_ram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/base_ram_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data (load/store),
// with data priority and a starvation bound that guarantees fetch progress.
module base_ram_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              inst_req_valid,
  output logic              inst_req_ready,
  input  logic [31:0]       inst_addr,
  input  logic              inst_cancel,
  output logic              inst_resp_valid,
  output logic [31:0]       inst_rdata,

  input  logic              data_req_valid,
  output logic              data_req_ready,
  input  logic              data_we,
  input  logic [3:0]        data_be,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_resp_valid,
  output logic [31:0]       data_rdata,

  output logic              ram_ce_n,
  output logic              ram_we_n,
  output logic [3:0]        ram_be_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,

  output logic              busy
);

  // Handshake: a request transfers in the cycle where valid & ready are both
  // high; the requester holds valid and payload until then, and ready is only
  // ever raised in IDLE for the single arbitration winner.

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

  localparam logic [1:0] LAT_INIT   = 2'(RAM_LAT - 1);
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  state_e              state_q;
  logic [1:0]          lat_cnt_q;
  logic [2:0]          starve_cnt_q, starve_cnt_d;
  logic                owner_data_q;
  logic                drop_q;
  logic                inst_pend_q, data_pend_q;
  logic [31:0]         inst_rdata_q, data_rdata_q;
  logic                ram_ce_n_q, ram_we_n_q;
  logic [3:0]          ram_be_n_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [31:0]         ram_wdata_q;

  logic idle, fetch_wins, inst_grant, data_grant, fetch_cancel;
  logic unused_addr_bits;

  assign idle         = (state_q == S_IDLE);
  assign fetch_wins   = inst_req_valid & (~data_req_valid | (starve_cnt_q == STARVE_LIM));
  assign inst_req_ready = resetn & idle & fetch_wins;
  assign data_req_ready = resetn & idle & data_req_valid & ~fetch_wins;
  assign inst_grant   = inst_req_valid & inst_req_ready;
  assign data_grant   = data_req_valid & data_req_ready;
  assign fetch_cancel = ~idle & ~owner_data_q & inst_cancel;

  assign unused_addr_bits = ^{inst_addr[1:0], inst_addr[31:ADDR_W+2],
                              data_addr[1:0], data_addr[31:ADDR_W+2]};

  // Counts data grants that overtook a waiting fetch; any gap in fetch
  // valid restarts the count.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!inst_req_valid || inst_grant) begin
      starve_cnt_d = '0;
    end else if (data_grant && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      owner_data_q <= 1'b0;
      drop_q       <= 1'b0;
      inst_pend_q  <= 1'b0;
      data_pend_q  <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      ram_ce_n_q   <= 1'b1;
      ram_we_n_q   <= 1'b1;
      ram_be_n_q   <= 4'b1111;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      inst_pend_q  <= 1'b0;
      data_pend_q  <= 1'b0;
      if (fetch_cancel) begin
        drop_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (inst_grant || data_grant) begin
            state_q      <= S_ACCESS;
            lat_cnt_q    <= LAT_INIT;
            owner_data_q <= data_grant;
            drop_q       <= 1'b0;
            ram_ce_n_q   <= 1'b0;
            if (data_grant) begin
              ram_addr_q  <= data_addr[ADDR_W+1:2];
              ram_we_n_q  <= ~data_we;
              ram_be_n_q  <= data_we ? ~data_be : 4'b0000;
              ram_wdata_q <= data_we ? data_wdata : 32'd0;
            end else begin
              ram_addr_q  <= inst_addr[ADDR_W+1:2];
              ram_we_n_q  <= 1'b1;
              ram_be_n_q  <= 4'b0000;
              ram_wdata_q <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (lat_cnt_q == 2'd0) begin
            state_q     <= S_IDLE;
            ram_ce_n_q  <= 1'b1;
            ram_we_n_q  <= 1'b1;
            ram_be_n_q  <= 4'b1111;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if (owner_data_q) begin
              data_pend_q  <= 1'b1;
              data_rdata_q <= ram_we_n_q ? ram_rdata : 32'd0;
            end else if (!(drop_q || inst_cancel)) begin
              // A cancel on the final cycle drops the response just like earlier ones.
              inst_pend_q  <= 1'b1;
              inst_rdata_q <= ram_rdata;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q - 2'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign inst_resp_valid = inst_pend_q & ~inst_cancel;
  assign inst_rdata      = inst_rdata_q;
  assign data_resp_valid = data_pend_q;
  assign data_rdata      = data_rdata_q;
  assign ram_ce_n        = ram_ce_n_q;
  assign ram_we_n        = ram_we_n_q;
  assign ram_be_n        = ram_be_n_q;
  assign ram_addr        = ram_addr_q;
  assign ram_wdata       = ram_wdata_q;
  assign busy            = ~idle;

endmodule

// File: tb/tb_base_ram_arbiter.sv
// Bench for base_ram_arbiter: directed scenarios plus a random phase, every
// cycle compared against a transaction-level model of grants, pins and responses.
module tb_base_ram_arbiter;

  localparam int ADDR_W = 20;
  localparam int LAT    = 3;
  localparam int SMAX   = 3;

  logic              clk;
  logic              resetn;
  logic              inst_req_valid, inst_req_ready, inst_cancel, inst_resp_valid;
  logic [31:0]       inst_addr, inst_rdata;
  logic              data_req_valid, data_req_ready, data_we, data_resp_valid;
  logic [3:0]        data_be;
  logic [31:0]       data_addr, data_wdata, data_rdata;
  logic              ram_ce_n, ram_we_n, busy;
  logic [3:0]        ram_be_n;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  base_ram_arbiter #(.ADDR_W(ADDR_W), .RAM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .resetn(resetn),
    .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
    .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_resp_valid(inst_resp_valid), .inst_rdata(inst_rdata),
    .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
    .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_resp_valid(data_resp_valid),
    .data_rdata(data_rdata),
    .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n), .ram_be_n(ram_be_n),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy)
  );

  // SRAM contents as a fixed function of the word address
  function automatic logic [31:0] mem_fn(input logic [ADDR_W-1:0] a);
    if (a == 20'h00004) return 32'h0280_0421;
    return {a[11:0], a} ^ 32'hC3A5_0F1E;
  endfunction

  assign ram_rdata = mem_fn(ram_addr);

  // reference model: one transaction window [acc_start, acc_end], response at acc_end+1
  int                cyc;
  int                acc_start, acc_end;
  bit                t_data, t_we, t_drop;
  logic [ADDR_W-1:0] t_addr;
  logic [3:0]        t_be;
  logic [31:0]       t_wdata;
  int                starve;
  logic [31:0]       m_irdata, m_drdata;
  bit                pre_ir, pre_dr;
  bit                g_inst, g_data;
  bit                obs_ir, obs_dr;
  logic [7:0]        exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit         in_acc, resp, store;
    logic [3:0] e_be_n;
    in_acc = (cyc >= acc_start) && (cyc <= acc_end);
    resp   = (cyc == acc_end + 1);
    store  = t_data && t_we;
    pre_ir = resetn && !in_acc && inst_req_valid && (!data_req_valid || starve == SMAX);
    pre_dr = resetn && !in_acc && data_req_valid && !pre_ir;
    e_be_n = !in_acc ? 4'b1111 : (store ? ~t_be : 4'b0000);
    chk("inst_ready", inst_req_ready, pre_ir);
    chk("data_ready", data_req_ready, pre_dr);
    chk("busy", busy, in_acc);
    chk("ram_ce_n", ram_ce_n, !in_acc);
    chk("ram_we_n", ram_we_n, !(in_acc && store));
    chk("ram_be_n", ram_be_n, e_be_n);
    chk("ram_addr", ram_addr, in_acc ? t_addr : '0);
    if (!in_acc) chk("ram_wdata_idle", ram_wdata, 32'd0);
    else if (store) chk("ram_wdata_store", ram_wdata, t_wdata);
    chk("inst_resp_valid", inst_resp_valid, resp && !t_data && !t_drop && !inst_cancel);
    chk("data_resp_valid", data_resp_valid, resp && t_data);
    chk("inst_rdata", inst_rdata, m_irdata);
    chk("data_rdata", data_rdata, m_drdata);
    obs_ir = inst_req_ready;
    obs_dr = data_req_ready;
  endtask

  task automatic update_model();
    bit in_acc;
    if (!resetn) begin
      acc_start = -100; acc_end = -100; starve = 0; t_drop = 0;
      m_irdata = '0; m_drdata = '0; g_inst = 0; g_data = 0;
      cyc++;
      return;
    end
    in_acc = (cyc >= acc_start) && (cyc <= acc_end);
    if (in_acc && !t_data && inst_cancel) t_drop = 1;
    if (cyc == acc_end) begin
      if (t_data) m_drdata = t_we ? 32'd0 : mem_fn(t_addr);
      else if (!t_drop) m_irdata = mem_fn(t_addr);
    end
    g_inst = pre_ir;
    g_data = pre_dr;
    if (g_inst || g_data) begin
      t_data    = g_data;
      t_we      = g_data && data_we;
      t_addr    = g_data ? data_addr[ADDR_W+1:2] : inst_addr[ADDR_W+1:2];
      t_be      = data_be;
      t_wdata   = data_wdata;
      t_drop    = 0;
      acc_start = cyc + 1;
      acc_end   = cyc + LAT;
    end
    if (!inst_req_valid || g_inst) starve = 0;
    else if (g_data && starve < SMAX) starve++;
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // driver tasks
  task automatic wait_grant(input bit want_inst);
    int n;
    bit got;
    n = 0;
    got = 0;
    while (!got && n < 40) begin
      tick();
      n++;
      got = want_inst ? g_inst : g_data;
    end
    if (want_inst) chk("inst_grant_wait", got, 1);
    else chk("data_grant_wait", got, 1);
  endtask

  task automatic req_fetch(input logic [31:0] a);
    inst_req_valid = 1'b1;
    inst_addr = a;
    wait_grant(1'b1);
    inst_req_valid = 1'b0;
  endtask

  task automatic req_data(input logic we, input logic [3:0] be,
                          input logic [31:0] a, input logic [31:0] wd);
    data_req_valid = 1'b1;
    data_we = we;
    data_be = be;
    data_addr = a;
    data_wdata = wd;
    wait_grant(1'b0);
    data_req_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] act, expc;
    resetn = 1'b0;
    inst_req_valid = 0; inst_addr = '0; inst_cancel = 0;
    data_req_valid = 0; data_we = 0; data_be = '0; data_addr = '0; data_wdata = '0;
    cyc = 0; acc_start = -100; acc_end = -100; starve = 0;
    t_data = 0; t_we = 0; t_drop = 0; t_addr = '0; t_be = '0; t_wdata = '0;
    m_irdata = '0; m_drdata = '0; g_inst = 0; g_data = 0;
    @(posedge clk);
    #1;
    idle_cycles(2);
    resetn = 1'b1;
    idle_cycles(2);

    // fetch only
    req_fetch(32'h8000_0010);
    idle_cycles(LAT + 2);
    chk("fetch_rdata", inst_rdata, 32'h0280_0421);

    // load, then stores (partial and empty byte enables)
    req_data(1'b0, 4'b0000, 32'h8000_0200, 32'd0);
    idle_cycles(LAT + 2);
    req_data(1'b1, 4'b0010, 32'h8000_0104, 32'h0000_AB00);
    idle_cycles(LAT + 2);
    chk("store_rdata", data_rdata, 32'd0);
    req_data(1'b1, 4'b0000, 32'h8000_0108, 32'h1234_5678);
    idle_cycles(LAT + 2);

    // cancel at T+1, data request waiting behind it
    req_fetch(32'h8000_0400);
    inst_cancel = 1'b1;
    data_req_valid = 1'b1; data_we = 1'b0; data_be = 4'hF;
    data_addr = 32'h8000_0500; data_wdata = '0;
    tick();
    inst_cancel = 1'b0;
    wait_grant(1'b0);
    data_req_valid = 1'b0;
    idle_cycles(LAT + 2);

    // starvation: both valid continuously
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(8'h44); exp_q.push_back(8'h44);
      exp_q.push_back(8'h44); exp_q.push_back(8'h49);
    end
    inst_req_valid = 1'b1; inst_addr = $urandom() & 32'hFFFF_FFFC;
    data_req_valid = 1'b1; data_we = 1'b0; data_addr = $urandom();
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      tick();
      n++;
      if (obs_ir || obs_dr) begin
        act = obs_ir ? 8'h49 : 8'h44;
        expc = exp_q.pop_front();
        chk("starve_order", act, expc);
      end
      if (g_inst) inst_addr = $urandom() & 32'hFFFF_FFFC;
      if (g_data) data_addr = $urandom();
    end
    chk("starve_done", exp_q.size(), 0);
    inst_req_valid = 1'b0;
    data_req_valid = 1'b0;
    idle_cycles(LAT + 2);

    // back-to-back loads
    data_req_valid = 1'b1; data_we = 1'b0; data_addr = $urandom();
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      tick();
      if (g_data) begin
        n++;
        data_addr = $urandom();
      end
    end
    chk("b2b_grants", n, 4);
    data_req_valid = 1'b0;
    idle_cycles(LAT + 2);

    // reset at T+1 of a load
    req_data(1'b0, 4'b0000, 32'h8000_0660, 32'd0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("rst_ce_n", ram_ce_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_data_resp", data_resp_valid, 0);
    inst_req_valid = 1'b1;
    inst_addr = 32'h8000_0010;
    tick();
    chk("fresh_fetch_grant", obs_ir, 1);
    inst_req_valid = 1'b0;
    idle_cycles(LAT + 2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (g_inst) inst_req_valid = 1'b0;
      if (g_data) data_req_valid = 1'b0;
      if (!inst_req_valid && $urandom_range(0, 2) == 0) begin
        inst_req_valid = 1'b1;
        inst_addr = $urandom() & 32'hFFFF_FFFC;
      end else if (inst_req_valid && $urandom_range(0, 15) == 0) begin
        inst_req_valid = 1'b0;
      end
      if (!data_req_valid && $urandom_range(0, 2) == 0) begin
        data_req_valid = 1'b1;
        data_we = 1'($urandom_range(0, 1));
        data_be = 4'($urandom_range(0, 15));
        data_addr = $urandom();
        data_wdata = $urandom();
      end
      inst_cancel = ($urandom_range(0, 5) == 0);
      tick();
    end
    inst_req_valid = 1'b0;
    data_req_valid = 1'b0;
    inst_cancel = 1'b0;
    idle_cycles(LAT + 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
